fpu_div_mant_seq: RTL and testbench

Sequential radix-2 restoring mantissa divider for the FPU divide path. It is the inverse datapath of the FPU_MUL mantissa multiplier: it produces the quotient mantissa plus guard/round bits and sticky, and feeds the existing normalise/round stage. Each iteration's trial subtraction is built from 4-bit carry-lookahead nibbles with grouped propagate/generate, the same style as the multiplier adders. Sign and exponent are handled outside this block.

---
 rtl/fpu_div_pkg.sv | 13 +
 rtl/fpu_div_cla_sub.sv | 41 ++++
 rtl/fpu_div_mant_seq.sv | 105 ++++++++++
 tb/tb_fpu_div_mant_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_div_pkg.sv
// Shared types and sizing for the FPU mantissa divider.
package fpu_div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int DEF_MANT_W = 24;
  localparam int DEF_QW     = DEF_MANT_W + 2;
  localparam int CNT_W      = $clog2(DEF_QW + 1);

  // Iteration counter width for an arbitrary mantissa width (QW = mant_w + 2).
  function automatic int cnt_width(input int mant_w);
    return $clog2(mant_w + 3);
  endfunction
endpackage

// File: rtl/fpu_div_cla_sub.sv
// Combinational a - b as a + ~b + 1 using 4-bit CLA nibbles chained by group P/G.
module fpu_div_cla_sub #(
  parameter int W = 25
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);
  localparam int NIB = (W + 3) / 4;
  localparam int PW  = NIB * 4;

  logic [PW-1:0] ap, bn;
  logic [NIB:0]  gc;

  // Zero-padding both operands keeps carry-out == (a >= b) in the top nibble.
  assign ap    = PW'(a);
  assign bn    = ~(PW'(b));
  assign gc[0] = 1'b1;

  for (genvar k = 0; k < NIB; k++) begin : g_nib
    logic [3:0] p, g, c;
    logic       gg, gp;
    assign p    = ap[4*k +: 4] ^ bn[4*k +: 4];
    assign g    = ap[4*k +: 4] & bn[4*k +: 4];
    assign c[0] = gc[k];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign gp   = &p;
    assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign gc[k+1] = gg | (gp & gc[k]);
    for (genvar j = 0; j < 4; j++) begin : g_bit
      if (4*k + j < W) begin : g_out
        assign diff[4*k + j] = p[j] ^ c[j];
      end
    end
  end

  assign borrow = ~gc[NIB];
endmodule

// File: rtl/fpu_div_mant_seq.sv
// Sequential radix-2 restoring mantissa divider: quotient with guard/round, sticky, ovf, div-by-zero.
module fpu_div_mant_seq
  import fpu_div_pkg::*;
#(
  parameter int MANT_W = DEF_MANT_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [MANT_W-1:0]   i_dividend,
  input  logic [MANT_W-1:0]   i_divisor,
  input  logic                i_ready,
  output logic                o_busy,
  output logic                o_valid,
  output logic [MANT_W+1:0]   o_quot,
  output logic                o_sticky,
  output logic                o_ovf,
  output logic                o_div_zero
);
  localparam int QW  = MANT_W + 2;
  localparam int RW  = MANT_W + 1;
  localparam int CW  = cnt_width(MANT_W);
  localparam logic [CW-1:0] LAST = CW'(QW - 1);

  state_t            state, state_n;
  logic [RW-1:0]     rem, rem_nxt, diff;
  logic [MANT_W-1:0] dvs;
  logic [QW-1:0]     quot;
  logic [CW-1:0]     cnt;
  logic              borrow, sticky, ovf, dz;

  fpu_div_cla_sub #(.W(RW)) u_sub (
    .a      (rem),
    .b      ({1'b0, dvs}),
    .diff   (diff),
    .borrow (borrow)
  );

  assign rem_nxt = borrow ? {rem[RW-2:0], 1'b0} : {diff[RW-2:0], 1'b0};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (i_start) state_n = (i_divisor == '0) ? DONE : CALC;
      CALC:    if (cnt == LAST) state_n = DONE;
      DONE:    if (i_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem    <= '0;
      dvs    <= '0;
      quot   <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
      ovf    <= 1'b0;
      dz     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          if (i_divisor == '0) begin
            quot   <= '1;
            sticky <= 1'b0;
            ovf    <= 1'b0;
            dz     <= 1'b1;
          end else begin
            rem    <= {1'b0, i_dividend};
            dvs    <= i_divisor;
            quot   <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
            ovf    <= ({1'b0, i_dividend} >= {i_divisor, 1'b0});
            dz     <= 1'b0;
          end
        end
        CALC: begin
          rem  <= rem_nxt;
          quot <= {quot[QW-2:0], ~borrow};
          cnt  <= cnt + CW'(1);
          // Sticky taken from the unshifted remainder of the final step.
          if (cnt == LAST) sticky <= borrow ? |rem : |diff;
        end
        DONE: if (i_ready) begin
          ovf <= 1'b0;
          dz  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = (state != IDLE);
  assign o_valid    = (state == DONE);
  assign o_quot     = quot;
  assign o_sticky   = sticky;
  assign o_ovf      = ovf;
  assign o_div_zero = dz;
endmodule

// File: tb/tb_fpu_div_mant_seq.sv
// Scoreboard bench for fpu_div_mant_seq: directed corner cases plus random normalised divides.
module tb_fpu_div_mant_seq;
  localparam int MW = 24;
  localparam int QW = MW + 2;

  typedef struct {
    logic [QW-1:0] quot;
    logic          sticky;
    logic          ovf;
    logic          dz;
    logic          chk_q;
    int            acc;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [MW-1:0] i_dividend = '0;
  logic [MW-1:0] i_divisor = '0;
  logic          i_ready = 1'b0;
  logic          o_busy, o_valid, o_sticky, o_ovf, o_div_zero;
  logic [QW-1:0] o_quot;

  int   n_chk = 0;
  int   n_fail = 0;
  int   edge_cnt = 0;
  exp_t sb[$];
  exp_t cur;
  logic prev_valid = 1'b0;
  logic take_pend = 1'b0;

  fpu_div_mant_seq #(.MANT_W(MW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (i_start),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .i_ready    (i_ready),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_quot     (o_quot),
    .o_sticky   (o_sticky),
    .o_ovf      (o_ovf),
    .o_div_zero (o_div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: q = floor(a * 2^(QW-1) / b) mod 2^QW, sticky = remainder != 0.
  function automatic exp_t model(input logic [MW-1:0] a, input logic [MW-1:0] b);
    exp_t e;
    longint unsigned num;
    num     = longint'(a) << (QW - 1);
    e.chk_q = 1'b1;
    e.acc   = 0;
    if (b == 0) begin
      e.quot = '1; e.sticky = 1'b0; e.ovf = 1'b0; e.dz = 1'b1;
      e.lat  = 0;  // DONE is entered on the accepting edge itself
    end else begin
      e.quot   = QW'((num / longint'(b)) % (64'd1 << QW));
      e.sticky = (num % longint'(b)) != 0;
      e.ovf    = longint'(a) >= 2 * longint'(b);
      e.dz     = 1'b0;
      e.lat    = QW;
    end
    return e;
  endfunction

  // Monitor: pops on o_valid rising, checks hold stability and release.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      take_pend  = 1'b0;
    end else begin
      if (take_pend) check("valid_drop", 64'(o_valid), 64'd0);
      if (o_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_valid: got valid=1, expected no result pending");
        end else begin
          cur = sb.pop_front();
          check("latency", 64'(edge_cnt - cur.acc), 64'(cur.lat));
          check("div_zero", 64'(o_div_zero), 64'(cur.dz));
          check("ovf", 64'(o_ovf), 64'(cur.ovf));
          if (cur.chk_q) begin
            check("quot", 64'(o_quot), 64'(cur.quot));
            check("sticky", 64'(o_sticky), 64'(cur.sticky));
          end
        end
      end else if (o_valid && prev_valid) begin
        check("hold_dz", 64'(o_div_zero), 64'(cur.dz));
        check("hold_ovf", 64'(o_ovf), 64'(cur.ovf));
        if (cur.chk_q) begin
          check("hold_quot", 64'(o_quot), 64'(cur.quot));
          check("hold_sticky", 64'(o_sticky), 64'(cur.sticky));
        end
      end
      take_pend  = o_valid && i_ready;
      prev_valid = o_valid;
    end
  end

  // mode: 0 normal, 1 stray start during CALC, 2 start on the release edge, 3 reset mid-op
  task automatic run_op(input logic [MW-1:0] a, input logic [MW-1:0] b, input int hold,
                        input int mode, input logic chk_q);
    exp_t e;
    int t;
    @(posedge clk); #1;
    i_start = 1'b1; i_dividend = a; i_divisor = b; i_ready = (hold < 0);
    @(negedge clk);
    e = model(a, b);
    e.chk_q = chk_q;
    e.acc = edge_cnt + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    i_start = 1'b0; i_dividend = MW'($urandom); i_divisor = MW'($urandom);
    if (mode == 1) begin
      repeat (4) @(posedge clk);
      #1; i_start = 1'b1; i_dividend = 24'hFFFFFF; i_divisor = 24'h800001;
      @(posedge clk); #1; i_start = 1'b0;
    end
    if (mode == 3) begin
      repeat (9) @(posedge clk);
      #2; rst_n = 1'b0;
      #1;
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_quot", 64'(o_quot), 64'd0);
      sb.delete();
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_idle", 64'(o_busy), 64'd0);
      return;
    end
    t = 0;
    while (!o_valid && t < 100) begin @(posedge clk); #1; t++; end
    if (!o_valid) begin
      n_chk++; n_fail++;
      $display("FAIL valid_timeout: got no valid in 100 cycles, expected valid");
      sb.delete(); i_ready = 1'b0;
      return;
    end
    if (hold >= 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      i_ready = 1'b1;
      if (mode == 2) begin i_start = 1'b1; i_dividend = a; i_divisor = b; end
      @(posedge clk); #1;
      i_ready = 1'b0; i_start = 1'b0;
      if (mode == 2) begin
        check("release_busy", 64'(o_busy), 64'd0);
        @(posedge clk); #1;
        check("start_on_release_ignored", 64'(o_busy), 64'd0);
      end
    end else begin
      t = 0;
      while (o_valid && t < 5) begin @(posedge clk); #1; t++; end
      i_ready = 1'b0;
    end
  endtask

  initial begin
    #12;
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_valid", 64'(o_valid), 64'd0);
    check("reset_quot", 64'(o_quot), 64'd0);
    check("reset_flags", 64'({o_sticky, o_ovf, o_div_zero}), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    run_op(24'hC00000, 24'h800000, 1, 0, 1'b1);   // 1.5/1.0
    run_op(24'h800000, 24'hC00000, 0, 0, 1'b1);   // 1.0/1.5
    run_op(24'hFFFFFF, 24'hFFFFFF, 10, 0, 1'b1);  // equal, long hold
    run_op(24'h800000, 24'h000000, 2, 0, 1'b1);   // divide by zero
    run_op(24'hC00000, 24'h400000, 0, 0, 1'b0);   // ovf flag only
    run_op(24'hA5A5A5, 24'hC3C3C3, 0, 1, 1'b1);   // stray start during CALC
    run_op(24'h9ABCDE, 24'hF00001, 1, 2, 1'b1);   // start on release edge
    run_op(24'hD00000, 24'h900000, 0, 3, 1'b1);   // reset mid-op
    run_op(24'hFFFFFF, 24'h800000, -1, 0, 1'b1);  // ready held high throughout

    for (int i = 0; i < 1000; i++) begin
      logic [MW-1:0] a, b;
      a = {1'b1, 23'($urandom)};
      b = {1'b1, 23'($urandom)};
      run_op(a, b, int'($urandom_range(0, 3)) - 1, 0, 1'b1);
    end

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
